// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-memory fetch block.
package imem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W    = 30;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_INIT_WORD = 1;

endpackage

// File: rtl/imem_if.sv
// Fetch, consume and program-load signals of the instruction memory, grouped as one bus.
interface imem_if #(
  parameter int DATA_W = imem_pkg::DEF_DATA_W,
  parameter int ADDR_W = imem_pkg::DEF_ADDR_W
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_ready;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic              instr_ready;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_ack;
  logic              init_done;
  logic              instr_perr;

  modport slave (
    input  fetch_req, fetch_pc, instr_ready, load_en, load_addr, load_data,
    output fetch_ready, instr_valid, instr, load_ack, init_done, instr_perr
  );

  modport master (
    output fetch_req, fetch_pc, instr_ready, load_en, load_addr, load_data,
    input  fetch_ready, instr_valid, instr, load_ack, init_done, instr_perr
  );

endinterface

// File: rtl/imem_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port (read-old on collision).
module imem_ram #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with INIT sweep, one-cycle fetch pipe and program-load port.
// Optional per-word even parity enabled by defining IMEM_PARITY_EN.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(DEF_INIT_WORD)
) (
  input  logic   clk,
  input  logic   rst,
  imem_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              run;
  logic              accept;
  logic              vld_p1;
  logic              fwd_p1;
  logic [DATA_W-1:0] fwd_data_p1;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wword;
  logic [MEM_W-1:0]  wdata_mem;
  logic [MEM_W-1:0]  rdata_mem;
  logic [DATA_W-1:0] instr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt == '1) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign run    = (state == RUN);
  assign accept = bus.fetch_req && bus.fetch_ready;

  // The INIT sweep owns the write port; program loads are ignored until RUN.
  always_comb begin
    we    = 1'b1;
    waddr = cnt;
    wword = INIT_WORD;
    if (run) begin
      we    = bus.load_en;
      waddr = bus.load_addr;
      wword = bus.load_data;
    end
  end

`ifdef IMEM_PARITY_EN
  assign wdata_mem = {even_par(wword), wword};
`else
  assign wdata_mem = wword;
`endif

  imem_ram #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata_mem),
    .re    (accept),
    .raddr (bus.fetch_pc),
    .rdata (rdata_mem)
  );

  // ---- stage p0 -> p1: fetch accepted, word available next cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (bus.instr_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // RAM reads the old word on a same-address load, so the new word is carried alongside.
  always_ff @(posedge clk) begin
    if (accept) begin
      fwd_p1      <= bus.load_en && (bus.load_addr == bus.fetch_pc);
      fwd_data_p1 <= bus.load_data;
    end
  end

  assign instr_data = fwd_p1 ? fwd_data_p1 : rdata_mem[DATA_W-1:0];

  assign bus.fetch_ready = run && (!vld_p1 || bus.instr_ready);
  assign bus.load_ack    = run && bus.load_en;
  assign bus.init_done   = run;
  assign bus.instr_valid = vld_p1;
  assign bus.instr       = vld_p1 ? instr_data : '0;

`ifdef IMEM_PARITY_EN
  assign bus.instr_perr = vld_p1 && !fwd_p1 &&
                          (rdata_mem[DATA_W] != even_par(rdata_mem[DATA_W-1:0]));
`else
  assign bus.instr_perr = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed scenarios plus randomized traffic against a memory-array model.
module tb_imem_fetch;

  localparam int DW = 30;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_if #(.DATA_W(DW), .ADDR_W(AW)) b ();

  imem_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_m [256];
  logic          exp_run;
  logic          exp_vld;
  logic [DW-1:0] exp_instr;

  task automatic model_init();
    for (int i = 0; i < 256; i++) mem_m[i] = DW'(1);
    exp_vld = 1'b0;
  endtask

  task automatic drive(input logic req, input logic [AW-1:0] pc, input logic rdy,
                       input logic ld, input logic [AW-1:0] la, input logic [DW-1:0] ldd);
    @(negedge clk);
    b.fetch_req   = req;
    b.fetch_pc    = pc;
    b.instr_ready = rdy;
    b.load_en     = ld;
    b.load_addr   = la;
    b.load_data   = ldd;
    #1;
  endtask

  function automatic logic model_ready();
    return exp_run && (!exp_vld || b.instr_ready);
  endfunction

  // Advance one clock, applying the memory rules to the reference model.
  task automatic tick();
    logic acc;
    acc = b.fetch_req && model_ready();
    if (exp_run && b.load_en) mem_m[b.load_addr] = b.load_data;
    if (acc) begin
      exp_vld   = 1'b1;
      exp_instr = mem_m[b.fetch_pc];
    end else if (b.instr_ready) begin
      exp_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int n, output logic seen_hi);
    n = 0;
    seen_hi = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (b.init_done) break;
      if (b.fetch_ready || b.load_ack) seen_hi = 1'b1;
    end
  endtask

  task automatic test_reset();
    int   n;
    logic seen;
    exp_run = 1'b0;
    rst = 1'b1;
    b.fetch_req = 1'b1; b.fetch_pc = 8'h05; b.instr_ready = 1'b1;
    b.load_en = 1'b1; b.load_addr = 8'h05; b.load_data = 30'h2AAAAAAA;
    repeat (2) @(posedge clk);
    #1;
    total++; if (b.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", b.instr_valid); end
    total++; if (b.instr !== '0) begin bad++; $display("FAIL rst_instr: got %h want 0", b.instr); end
    total++; if (b.instr_perr !== 1'b0) begin bad++; $display("FAIL rst_perr: got %b want 0", b.instr_perr); end
    total++; if (b.init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done: got %b want 0", b.init_done); end
    total++; if (b.load_ack !== 1'b0) begin bad++; $display("FAIL rst_load_ack: got %b want 0", b.load_ack); end
    total++; if (b.fetch_ready !== 1'b0) begin bad++; $display("FAIL rst_fetch_ready: got %b want 0", b.fetch_ready); end
    @(negedge clk);
    rst = 1'b0;
    wait_init(n, seen);
    total++; if (n != 256) begin bad++; $display("FAIL init_len: got %0d want 256", n); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL init_quiet: got %b want 0", seen); end
    model_init();
    exp_run = 1'b1;
  endtask

  task automatic test_nop_fetch();
    drive(1'b1, 8'h10, 1'b1, 1'b0, 8'h00, '0);
    tick();
    total++; if (b.instr_valid !== 1'b1) begin bad++; $display("FAIL nop_valid: got %b want 1", b.instr_valid); end
    total++; if (b.instr !== 30'h0000001) begin bad++; $display("FAIL nop_instr: got %h want 0000001", b.instr); end
    drive(1'b1, 8'h05, 1'b1, 1'b0, 8'h00, '0);
    tick();
    total++; if (b.instr !== 30'h0000001) begin bad++; $display("FAIL init_load_ignored: got %h want 0000001", b.instr); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, '0);
    tick();
    total++; if (b.instr_valid !== 1'b0) begin bad++; $display("FAIL valid_clear: got %b want 0", b.instr_valid); end
  endtask

  task automatic test_load_fwd();
    drive(1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 30'h3ABCDEF);
    total++; if (b.load_ack !== 1'b1) begin bad++; $display("FAIL load_ack: got %b want 1", b.load_ack); end
    tick();
    total++; if (b.instr !== 30'h3ABCDEF) begin bad++; $display("FAIL fwd_instr: got %h want 3abcdef", b.instr); end
    drive(1'b1, 8'h07, 1'b1, 1'b1, 8'h06, 30'h1234567);
    tick();
    total++; if (b.instr !== 30'h0000001) begin bad++; $display("FAIL diff_addr: got %h want 0000001", b.instr); end
    drive(1'b1, 8'h06, 1'b1, 1'b0, 8'h00, '0);
    tick();
    total++; if (b.instr !== 30'h1234567) begin bad++; $display("FAIL load_readback: got %h want 1234567", b.instr); end
    drive(1'b1, 8'h05, 1'b1, 1'b0, 8'h00, '0);
    tick();
    total++; if (b.instr !== 30'h3ABCDEF) begin bad++; $display("FAIL fwd_stored: got %h want 3abcdef", b.instr); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] held;
    drive(1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 30'h0C0FFEE);
    tick();
    drive(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, '0);
    tick();
    held = b.instr;
    total++; if (held !== 30'h0C0FFEE) begin bad++; $display("FAIL stall_first: got %h want 0c0ffee", held); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, '0);
      total++; if (b.fetch_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b want 0", b.fetch_ready); end
      tick();
      total++; if (b.instr !== held || b.instr_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold: got %h/%b want %h/1", b.instr, b.instr_valid, held);
      end
    end
    drive(1'b1, 8'h10, 1'b1, 1'b0, 8'h00, '0);
    total++; if (b.fetch_ready !== 1'b1) begin bad++; $display("FAIL stall_release: got %b want 1", b.fetch_ready); end
    tick();
    total++; if (b.instr !== 30'h0000001) begin bad++; $display("FAIL stall_next: got %h want 0000001", b.instr); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] r;
      r = $urandom;
      drive(1'b1, AW'(8'h40 + i), 1'b1, 1'b1, AW'(8'h40 + i), r[DW-1:0]);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(8'h40 + i), 1'b1, 1'b0, 8'h00, '0);
      tick();
      total++; if (b.instr_valid !== 1'b1 || b.instr !== exp_instr) begin
        bad++; $display("FAIL b2b_%0d: got %h/%b want %h/1", i, b.instr, b.instr_valid, exp_instr);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      logic        exp_rdy;
      r = $urandom;
      drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), r[DW-1:0]);
      exp_rdy = model_ready();
      total++; if (b.fetch_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", i, b.fetch_ready, exp_rdy); end
      total++; if (b.load_ack !== b.load_en) begin bad++; $display("FAIL rnd_ack@%0d: got %b want %b", i, b.load_ack, b.load_en); end
      tick();
      total++; if (b.instr_valid !== exp_vld) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, b.instr_valid, exp_vld); end
      if (exp_vld) begin
        total++; if (b.instr !== exp_instr) begin bad++; $display("FAIL rnd_instr@%0d: got %h want %h", i, b.instr, exp_instr); end
      end
      total++; if (b.instr_perr !== 1'b0) begin bad++; $display("FAIL rnd_perr@%0d: got %b want 0", i, b.instr_perr); end
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    logic seen;
    drive(1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 30'h1111111);
    tick();
    total++; if (b.instr_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", b.instr_valid); end
    @(negedge clk);
    rst = 1'b1;
    b.fetch_req = 1'b0; b.load_en = 1'b0; b.instr_ready = 1'b0;
    exp_run = 1'b0;
    @(posedge clk);
    #1;
    total++; if (b.instr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", b.instr_valid); end
    total++; if (b.init_done !== 1'b0) begin bad++; $display("FAIL mid_init_done: got %b want 0", b.init_done); end
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_init(n, seen);
    total++; if (n != 256) begin bad++; $display("FAIL reinit_len: got %0d want 256", n); end
    model_init();
    exp_run = 1'b1;
    drive(1'b1, 8'h05, 1'b1, 1'b0, 8'h00, '0);
    tick();
    total++; if (b.instr !== 30'h0000001) begin bad++; $display("FAIL reinit_05: got %h want 0000001", b.instr); end
    drive(1'b1, 8'h06, 1'b1, 1'b0, 8'h00, '0);
    tick();
    total++; if (b.instr !== 30'h0000001) begin bad++; $display("FAIL reinit_06: got %h want 0000001", b.instr); end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    @(negedge clk);
    dut.u_ram.mem[32] = dut.u_ram.mem[32] ^ 31'h0000004;
    drive(1'b1, 8'h20, 1'b1, 1'b0, 8'h00, '0);
    tick();
    total++; if (b.instr_perr !== 1'b1 || b.instr_valid !== 1'b1) begin
      bad++; $display("FAIL perr_flip: got %b/%b want 1/1", b.instr_perr, b.instr_valid);
    end
    drive(1'b1, 8'h21, 1'b1, 1'b0, 8'h00, '0);
    tick();
    total++; if (b.instr_perr !== 1'b0) begin bad++; $display("FAIL perr_clean: got %b want 0", b.instr_perr); end
  endtask
`endif

  initial begin
    test_reset();
    test_nop_fetch();
    test_load_fwd();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
